// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: opcode and FSM state encodings plus op-class helpers.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DIV   = 2'd2,
    ST_FIXUP = 2'd3
  } mdu_state_e;

  function automatic logic isMulOp(mdu_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic isDivOp(mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic isSignedOp(mdu_op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring-divide step: shift the next dividend bit into the partial remainder,
// subtract the divisor and keep the difference only when it does not go negative.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor always holds, so the trial difference fits in WIDTH+1 bits and its MSB is the sign
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    remNext = shifted[WIDTH-1:0];
    quoNext = {quo[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      remNext = trial[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit: iterative shift-add multiply and restoring divide.
// Define MDU_FAST_MULT_EN to replace the iterative multiply with a single-cycle multiplier.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iStart,
  input  logic [MDU_OP_W-1:0] iOp,
  input  logic [WIDTH-1:0]    iA,
  input  logic [WIDTH-1:0]    iB,
  input  logic                iFlush,
  output logic                oBusy,
  output logic                oDone,
  output logic                oDivByZero,
  output logic [WIDTH-1:0]    oHI,
  output logic [WIDTH-1:0]    oLO
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_e         state, nextState;
  mdu_op_e            opIn, opReg;
  logic [WIDTH-1:0]   hiReg, loReg, accHi, accLo, operand;
  logic [CNT_W-1:0]   iterCnt;
  logic               negRes, negRem, doneReg, dbzReg;

  logic               accept, divZero, aNeg, bNeg, lastIter;
  logic [WIDTH-1:0]   aMag, bMag, divRem, divQuo;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] prodMag, prodRes, fixupHiLo;

  function automatic logic [2*WIDTH-1:0] accumulate(mdu_op_e op, logic [2*WIDTH-1:0] base,
                                                    logic [2*WIDTH-1:0] prod);
    case (op)
      OP_MADD: return base + prod;
      OP_MSUB: return base - prod;
      default: return prod;
    endcase
  endfunction

  assign opIn     = mdu_op_e'(iOp);
  assign accept   = (state == ST_IDLE) && iStart && !iFlush;
  assign divZero  = isDivOp(opIn) && (iB == '0);
  assign aNeg     = isSignedOp(opIn) && iA[WIDTH-1];
  assign bNeg     = isSignedOp(opIn) && iB[WIDTH-1];
  assign aMag     = aNeg ? (~iA + 1'b1) : iA;
  assign bMag     = bNeg ? (~iB + 1'b1) : iB;
  assign lastIter = (iterCnt == CNT_W'(WIDTH - 1));

  // Shift-add step: accLo holds the unconsumed multiplier bits, product grows in from the top
  assign mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);

  mdu_div_core #(.WIDTH(WIDTH)) uDivCore (
    .rem     (accHi),
    .quo     (accLo),
    .divisor (operand),
    .remNext (divRem),
    .quoNext (divQuo)
  );

  assign prodMag   = {accHi, accLo};
  assign prodRes   = negRes ? (~prodMag + 1'b1) : prodMag;
  assign fixupHiLo = accumulate(opReg, {hiReg, loReg}, prodRes);

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] aExt, bExt, fastProd;
  assign aExt     = {{WIDTH{aNeg}}, iA};
  assign bExt     = {{WIDTH{bNeg}}, iB};
  assign fastProd = aExt * bExt;
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= ST_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
`ifndef MDU_FAST_MULT_EN
          if (isMulOp(opIn)) nextState = ST_MUL;
`endif
          if (isDivOp(opIn) && !divZero) nextState = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: if (lastIter) nextState = ST_FIXUP;
      ST_FIXUP:       nextState = ST_IDLE;
      default:        nextState = ST_IDLE;
    endcase
    if (iFlush) nextState = ST_IDLE;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hiReg   <= '0;
      loReg   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      operand <= '0;
      iterCnt <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      opReg   <= OP_MULT;
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      dbzReg  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opReg   <= opIn;
            iterCnt <= '0;
            accHi   <= '0;
            negRes  <= aNeg ^ bNeg;
            negRem  <= aNeg;
            case (opIn)
              OP_MTHI: begin
                hiReg   <= iA;
                doneReg <= 1'b1;
              end
              OP_MTLO: begin
                loReg   <= iA;
                doneReg <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (divZero) begin
                  hiReg   <= iA;
                  loReg   <= '1;
                  doneReg <= 1'b1;
                  dbzReg  <= 1'b1;
                end else begin
                  accLo   <= aMag;
                  operand <= bMag;
                end
              end
              default: begin
`ifdef MDU_FAST_MULT_EN
                {hiReg, loReg} <= accumulate(opIn, {hiReg, loReg}, fastProd);
                doneReg        <= 1'b1;
`else
                accLo   <= bMag;
                operand <= aMag;
`endif
              end
            endcase
          end
        end
        ST_MUL: begin
          accHi   <= mulSum[WIDTH:1];
          accLo   <= {mulSum[0], accLo[WIDTH-1:1]};
          iterCnt <= iterCnt + 1'b1;
        end
        ST_DIV: begin
          accHi   <= divRem;
          accLo   <= divQuo;
          iterCnt <= iterCnt + 1'b1;
        end
        ST_FIXUP: begin
          // A flush arriving with completion wins: HI/LO keep their pre-op values
          if (!iFlush) begin
            if (isMulOp(opReg)) begin
              {hiReg, loReg} <= fixupHiLo;
            end else begin
              loReg <= negRes ? (~accLo + 1'b1) : accLo;
              hiReg <= negRem ? (~accHi + 1'b1) : accHi;
            end
            doneReg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign oBusy      = (state != ST_IDLE);
  assign oDone      = doneReg;
  assign oDivByZero = dbzReg;
  assign oHI        = hiReg;
  assign oLO        = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected HI/LO, a monitor checks on oDone.
`timescale 1ns/1ps
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int WIDTH = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int      MUL_LAT  = 1;
  localparam mdu_op_e FLUSH_OP = OP_DIV;
`else
  localparam int      MUL_LAT  = WIDTH + 2;
  localparam mdu_op_e FLUSH_OP = OP_MULT;
`endif
  localparam int DIV_LAT = WIDTH + 2;

  logic                iCLK   = 1'b0;
  logic                iRST_n = 1'b0;
  logic                iStart = 1'b0;
  logic                iFlush = 1'b0;
  logic [MDU_OP_W-1:0] iOp    = '0;
  logic [WIDTH-1:0]    iA     = '0;
  logic [WIDTH-1:0]    iB     = '0;
  logic                oBusy, oDone, oDivByZero;
  logic [WIDTH-1:0]    oHI, oLO;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
  } exp_t;

  exp_t sb[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iStart     (iStart),
    .iOp        (iOp),
    .iA         (iA),
    .iB         (iB),
    .iFlush     (iFlush),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oDivByZero (oDivByZero),
    .oHI        (oHI),
    .oLO        (oLO)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: every oDone must match the oldest outstanding expectation
  always @(negedge iCLK) begin
    if (oDone === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        monExp = sb.pop_front();
        check("HI", oHI, monExp.hi);
        check("LO", oLO, monExp.lo);
        check("DBZ", oDivByZero, monExp.dbz);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge of the oDone cycle
  task automatic issue(input string name, input mdu_op_e op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] eHi,
                       input logic [WIDTH-1:0] eLo, input logic eDbz, input int eLat);
    int   lat  = 0;
    int   busy = 0;
    exp_t e;
    e.hi  = eHi;
    e.lo  = eLo;
    e.dbz = eDbz;
    sb.push_back(e);
    iStart = 1'b1;
    iOp    = op;
    iA     = a;
    iB     = b;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge iCLK);
      if (oDone === 1'b1) begin
        lat = k;
        break;
      end
      if (oBusy === 1'b1) busy++;
    end
    check({name, "_latency"}, lat, eLat);
    check({name, "_busy_cycles"}, busy, eLat - 1);
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_dbz", oDivByZero, 0);
    check("rst_hi", oHI, 0);
    check("rst_lo", oLO, 0);
    iRST_n = 1'b1;

    issue("mult_neg",  OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT);
    issue("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT);
    issue("divu",      OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 1'b0, DIV_LAT);
    issue("div_zero",  OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1);
    issue("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, DIV_LAT);
    issue("mthi",      OP_MTHI,  32'd0,        32'd0,        32'd0,        32'h80000000, 1'b0, 1);
    issue("mtlo",      OP_MTLO,  32'd10,       32'd0,        32'd0,        32'd10,       1'b0, 1);
    issue("madd",      OP_MADD,  32'd4,        32'd5,        32'd0,        32'd30,       1'b0, MUL_LAT);
    issue("msub",      OP_MSUB,  32'd40,       32'd1,        32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0, MUL_LAT);
    issue("multu_big", OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, 1'b0, MUL_LAT);
    issue("mult_m1m1", OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, MUL_LAT);
    issue("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, DIV_LAT);
    issue("mult_min",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0, MUL_LAT);

    // Start ignored while busy, then flush: nothing written, no oDone
    iStart = 1'b1; iOp = FLUSH_OP; iA = 32'd5; iB = 32'd6;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    repeat (4) @(posedge iCLK);
    #1 iStart = 1'b1; iOp = OP_MTHI; iA = 32'h00001234;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    check("ignore_busy", oBusy, 1);
    check("ignore_hi", oHI, 32'h40000000);
    repeat (4) @(posedge iCLK);
    #1 iFlush = 1'b1;
    @(posedge iCLK);
    #1 iFlush = 1'b0;
    check("flush_busy", oBusy, 0);
    repeat (40) @(negedge iCLK);
    check("flush_hi", oHI, 32'h40000000);
    check("flush_lo", oLO, 32'd0);

    // Flush and start together in IDLE: the flush wins
    iStart = 1'b1; iFlush = 1'b1; iOp = OP_MTHI; iA = 32'h0000DEAD;
    @(posedge iCLK);
    #1 iStart = 1'b0; iFlush = 1'b0;
    repeat (3) @(negedge iCLK);
    check("idle_flush_hi", oHI, 32'h40000000);
    check("idle_flush_busy", oBusy, 0);

    // Asynchronous reset in the middle of a divide
    iStart = 1'b1; iOp = OP_DIV; iA = 32'd100; iB = 32'd7;
    @(posedge iCLK);
    #1 iStart = 1'b0;
    repeat (10) @(posedge iCLK);
    check("pre_rst_busy", oBusy, 1);
    #2 iRST_n = 1'b0;
    #1;
    check("mid_rst_busy", oBusy, 0);
    check("mid_rst_hi", oHI, 0);
    check("mid_rst_lo", oLO, 0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    issue("post_rst_mtlo", OP_MTLO, 32'h00000055, 32'd0, 32'd0, 32'h00000055, 1'b0, 1);

    repeat (3) @(negedge iCLK);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
